psum_accumulator: RTL
=====================

Name: psum_accumulator

Overview:
- Sits directly downstream of the 14-input adder tree in a PE column.
- Accumulates a configurable number of consecutive 16-bit adder-tree sums, one per filter-row/channel pass, into one partial sum.
- Emits the partial sum over a valid/ready handshake toward the global buffer.
- Provides signed saturation and a sticky per-group overflow flag.

Parameters:
- DATA_W, 16, width of adder-tree sum, accumulator and output (signed two's complement).
- MAX_PASSES, 16, maximum number of sums per output group.
- CNT_W, $clog2(MAX_PASSES+1), width of the pass configuration and counter.
- SATURATE, 1, 1 = saturating accumulate; 0 = wrap-around accumulate (matches adder-tree wrap).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort: drop the current group and any held output.
- cfg_passes  input  CNT_W  sums per group; sampled only on the first beat of a group.
- in_valid  input  1  adder-tree sum valid.
- in_ready  output  1  accumulator can accept a sum this cycle.
- in_data  input  DATA_W  signed adder-tree sum.
- out_valid  output  1  partial sum available.
- out_ready  input  1  consumer accepts partial sum.
- out_data  output  DATA_W  signed accumulated partial sum.
- out_sat  output  1  at least one saturation (or, when SATURATE=0, overflow) occurred in this group; qualified by out_valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, acc=0, cnt=0, passes_q=0.
  - out_valid=0, out_data=0, out_sat=0, sat_q=0.
  - in_ready is combinational and therefore 1 immediately after reset.
- Beat accepted = in_valid & in_ready. Output accepted = out_valid & out_ready.
- in_ready = (state!=OUT) | out_ready. It is combinational from out_ready and has no dependency on in_valid.
- States:
  - IDLE: no group open.
    - On an accepted beat: passes_q = max(cfg_passes,1), clamped to MAX_PASSES.
    - acc=in_data, cnt=1, sat_q=0.
    - If passes_q==1, go to OUT; else go to ACCUM.
  - ACCUM: on an accepted beat, acc=f(acc,in_data) and cnt++.
    - If the new cnt==passes_q, go to OUT.
    - Cycles with in_valid=0 hold all state; no timeout.
  - OUT: out_valid=1, out_data=acc, out_sat=sat_q, all held stable until accepted.
    - On output accepted with no accepted beat in the same cycle: go to IDLE, out_valid=0.
    - On output accepted with an accepted beat in the same cycle: that beat opens the next group exactly as from IDLE, with no bubble.
- Latency: out_valid rises on the clock edge that accepts the last beat of a group, i.e. it is visible the cycle after the last in_valid/in_ready handshake.
- Throughput: sustains one sum per cycle. Back-to-back groups lose no cycles while out_ready=1.
- Arithmetic f(a,b) with a full (DATA_W+1)-bit signed add:
  - SATURATE=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; set sat_q if the clamp was applied.
  - SATURATE=0: wrap modulo 2^DATA_W; set sat_q on signed overflow.
  - The first beat of a group is loaded directly and never sets sat_q.
- Once a group is open, cfg_passes changes do not affect it.
- clear has priority over all handshakes in the same cycle:
  - state=IDLE, out_valid=0, cnt=0, sat_q=0.
  - acc and out_data keep their value.
  - The input beat presented that cycle is not consumed; in_ready is forced to 0 while clear=1.
- Asynchronous reset mid-group discards the group entirely; no partial output is emitted.
- out_data and out_sat must not change while out_valid=1 and out_ready=0.

Test Plan:
- Basic group: cfg_passes=4, beats 10,20,30,40 on consecutive cycles, out_ready=1 -> one out_valid pulse, out_data=100, out_sat=0, one cycle after the 4th beat.
- Saturation: cfg_passes=2, beats 30000,10000 -> out_data=32767, out_sat=1. Beats -30000,-10000 -> out_data=-32768, out_sat=1. With SATURATE=0, 30000+10000 -> out_data=-25536, out_sat=1.
- Backpressure and bubble-free restart: cfg_passes=2, beats 5,6, out_ready=0 for 3 cycles -> in_ready=0 and out_data=11 held stable. Then out_ready=1 with in_valid=1, in_data=7 on the same cycle -> 11 is accepted and 7 opens the new group. Next beat 8 -> out_data=15.
- Config edges: cfg_passes=0 and cfg_passes=1 -> each beat appears directly as out_data (in=-3 -> out=-3). cfg_passes changed from 3 to 2 mid-group -> the group still takes 3 beats.
- Abort and reset: cfg_passes=4, two beats accepted, then clear=1 with in_valid=1 -> in_ready=0, no output. A fresh group 1,1,1,1 -> out_data=4. Repeat with rst_n pulsed low mid-group -> all outputs 0 immediately, the next full group sums correctly.
- Stalled input: cfg_passes=3, beats 2, (4 idle cycles), 3, (1 idle cycle), 4 -> out_data=9 exactly once; out_valid never asserts before the 3rd beat.

Source files
------------

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator placed after the PE-column adder tree.
// Sums cfg_passes consecutive signed beats into one partial sum and
// hands it to the global buffer over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous abort of open group and held output
//   cfg_passes        beats per group, sampled on a group's first beat
//   in_valid/in_ready/in_data     adder-tree sum handshake
//   out_valid/out_ready/out_data  partial sum handshake
//   out_sat           sticky saturation/overflow flag of the group
module psum_accumulator #(
    parameter int DATA_W     = 16,
    parameter int MAX_PASSES = 16,
    parameter int CNT_W      = $clog2(MAX_PASSES + 1),
    parameter bit SATURATE   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [CNT_W-1:0]         cfg_passes,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_e;

    localparam logic [DATA_W-1:0] MAX_V =
        {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V =
        {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PASSES);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         passes_q, passes_d;
    logic                     sat_q, sat_d;

    logic [CNT_W-1:0]  cfg_clamped;
    logic [DATA_W:0]   sum_wide;
    logic [DATA_W-1:0] sum_res;
    logic              sum_ovf;
    logic              beat;
    logic              out_acc;
    logic              open_grp;

    assign out_valid = (state_q == OUT);
    // Held output blocks input unless it drains this very cycle.
    assign in_ready  = !clear && (!out_valid || out_ready);
    assign beat      = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready && !clear;
    assign out_data  = acc_q;
    assign out_sat   = sat_q;

    always_comb begin
        cfg_clamped = cfg_passes;
        if (cfg_passes == '0) begin
            cfg_clamped = ONE;
        end else if (cfg_passes > MAXP) begin
            cfg_clamped = MAXP;
        end
    end

    // One extra bit gives the exact sum; top two bits differing
    // means the result does not fit in DATA_W.
    always_comb begin
        sum_wide = {acc_q[DATA_W-1], acc_q}
                 + {in_data[DATA_W-1], in_data};
        sum_ovf  = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];
        sum_res  = sum_wide[DATA_W-1:0];
        if (SATURATE && sum_ovf) begin
            sum_res = sum_wide[DATA_W] ? MIN_V : MAX_V;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        passes_d = passes_q;
        sat_d    = sat_q;
        open_grp = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    open_grp = beat;
                end
                ACCUM: begin
                    if (beat) begin
                        acc_d = sum_res;
                        cnt_d = cnt_q + ONE;
                        sat_d = sat_q | sum_ovf;
                        if (cnt_d == passes_q) begin
                            state_d = OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_acc) begin
                        state_d  = IDLE;
                        open_grp = beat;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // First beat is loaded as-is; it can never overflow.
            if (open_grp) begin
                passes_d = cfg_clamped;
                acc_d    = in_data;
                cnt_d    = ONE;
                sat_d    = 1'b0;
                state_d  = (cfg_clamped == ONE) ? OUT : ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            passes_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            passes_q <= passes_d;
            sat_q    <= sat_d;
        end
    end

endmodule
